fifo_rr_arbiter: RTL and testbench

Round-robin drain arbiter that shares one downstream `fifo` write port among `N_REQ` upstream `fifo` instances. It pops the source FIFOs in bursts of up to `BURST_LEN` words, forwards each popped word to the destination FIFO one cycle later, and honours destination full/almost-full backpressure so no word is ever dropped. It sits between the per-lane FIFOs and the shared output FIFO and owns every `rd_en`/`wr_en` on that path.

---
 rtl/fifo_rr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain arbiter: pops source FIFOs in bounded bursts and forwards
// each popped word to one shared destination FIFO one cycle later.
module fifo_rr_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BURST_LEN  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [N_REQ-1:0]              req_mask,
  input  logic [N_REQ-1:0]              src_empty,
  input  logic [N_REQ*DATA_WIDTH-1:0]   src_data,
  output logic [N_REQ-1:0]              src_rd_en,
  input  logic                          dst_full,
  input  logic                          dst_almost_full,
  output logic                          dst_wr_en,
  output logic [DATA_WIDTH-1:0]         dst_data,
  output logic [N_REQ-1:0]              grant,
  output logic                          busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [N_REQ-1:0]      grant_nxt;
  logic [N_REQ-1:0]      elig;
  logic [IDX_W-1:0]      last, last_nxt;
  logic [IDX_W-1:0]      g_idx, pick_idx, sel_d;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  vld_d, pick_vld, pop;
  logic [DATA_WIDTH-1:0] src_word [N_REQ];

  assign elig = req_mask & ~src_empty;

  // Unpack the flat source bus into per-lane words
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      src_word[k] = src_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Index of the current one-hot owner
  always_comb begin
    g_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) g_idx = IDX_W'(k);
    end
  end

  // First eligible source searching circularly from last+1
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!pick_vld && elig[IDX_W'((32'(last) + k) % N_REQ)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((32'(last) + k) % N_REQ);
      end
    end
  end

  // Pops stop at almost-full so the single in-flight word always has a slot
  assign pop = (state == BURST) & enable & elig[g_idx] & ~dst_full & ~dst_almost_full
             & (cnt < CNT_W'(BURST_LEN)) & ~rst;

  assign src_rd_en = pop ? grant : '0;
  assign dst_wr_en = vld_d;
  assign dst_data  = vld_d ? src_word[sel_d] : '0;
  assign busy      = (state == BURST) | vld_d;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (enable && pick_vld) begin
          state_nxt = BURST;
          grant_nxt = N_REQ'(1) << pick_idx;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (pop) cnt_nxt = cnt + CNT_W'(1);
        if ((cnt_nxt == CNT_W'(BURST_LEN)) || !elig[g_idx] || !enable) begin
          state_nxt = IDLE;
          last_nxt  = g_idx;
          grant_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= IDX_W'(N_REQ - 1);
      cnt   <= '0;
      vld_d <= 1'b0;
      sel_d <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      vld_d <= pop;
      sel_d <= g_idx;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: queue-based source FIFOs, a transaction-level
// reference model of the arbitration rules, directed steps then random traffic.
module tb_fifo_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned BL = 2;

  logic            clk = 1'b0;
  logic            rst, enable, dst_full, dst_almost_full;
  logic [N-1:0]    req_mask, src_empty, src_rd_en, grant;
  logic [N*DW-1:0] src_data;
  logic            dst_wr_en, busy;
  logic [DW-1:0]   dst_data;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_mask(req_mask),
    .src_empty(src_empty), .src_data(src_data), .src_rd_en(src_rd_en),
    .dst_full(dst_full), .dst_almost_full(dst_almost_full),
    .dst_wr_en(dst_wr_en), .dst_data(dst_data), .grant(grant), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] srcq [N][$];
  logic [DW-1:0] out_reg [N];
  int            pop_log [$];
  logic [DW-1:0] push_log [$];

  // Reference model: owner/previous owner as plain ints, pending word as a value
  bit            m_burst, m_infl;
  int            m_own, m_prev, m_cnt;
  logic [DW-1:0] m_word;

  int rr_pops [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
  int rr_data [12] = '{1, 2, 5, 6, 9, 10, 13, 14, 3, 7, 11, 15};
  int sh_pops [7]  = '{0, 0, 1, 2, 2, 3, 3};
  int mk_pops [8]  = '{0, 0, 2, 2, 0, 0, 2, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit elig_m(input int k);
    return req_mask[k] && (srcq[k].size() != 0);
  endfunction

  task automatic drive_src();
    for (int k = 0; k < N; k++) begin
      src_empty[k]          = (srcq[k].size() == 0);
      src_data[k*DW +: DW]  = out_reg[k];
    end
  endtask

  task automatic load(input int k, input logic [DW-1:0] w);
    srcq[k].push_back(w);
    drive_src();
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < N; k++) srcq[k].delete();
    drive_src();
  endtask

  // One clock: check outputs against the model, then advance model and sources
  task automatic cycle();
    bit            e_pop, n_burst, n_infl;
    int            n_own, n_prev, n_cnt;
    logic [DW-1:0] n_word;
    logic [N-1:0]  e_rd, e_gnt, obs_rd;
    #1;
    e_pop = m_burst && enable && elig_m(m_own) && !dst_full && !dst_almost_full
            && (m_cnt < int'(BL)) && !rst;
    e_gnt = m_burst ? N'(1 << m_own) : '0;
    e_rd  = e_pop ? e_gnt : '0;
    chk("src_rd_en", 32'(src_rd_en), 32'(e_rd));
    chk("grant", 32'(grant), 32'(e_gnt));
    chk("dst_wr_en", 32'(dst_wr_en), 32'(m_infl));
    chk("dst_data", 32'(dst_data), m_infl ? 32'(m_word) : 32'(0));
    chk("busy", 32'(busy), 32'(m_burst || m_infl));
    obs_rd = src_rd_en;
    for (int k = 0; k < N; k++) if (obs_rd[k]) pop_log.push_back(k);
    if (dst_wr_en) push_log.push_back(dst_data);

    n_burst = m_burst; n_infl = m_infl; n_own = m_own; n_prev = m_prev;
    n_cnt = m_cnt; n_word = m_word;
    if (rst) begin
      n_burst = 0; n_infl = 0; n_own = 0; n_prev = N - 1; n_cnt = 0;
    end else begin
      n_infl = e_pop;
      if (e_pop) n_word = srcq[m_own][0];
      if (m_burst) begin
        if (e_pop) n_cnt = m_cnt + 1;
        if (n_cnt == int'(BL) || !elig_m(m_own) || !enable) begin
          n_burst = 0;
          n_prev  = m_own;
        end
      end else if (enable) begin
        for (int s = 1; s <= N; s++) begin
          if (elig_m((m_prev + s) % N)) begin
            n_own = (m_prev + s) % N; n_burst = 1; n_cnt = 0;
            break;
          end
        end
      end
    end

    @(posedge clk);
    #1;
    m_burst = n_burst; m_infl = n_infl; m_own = n_own; m_prev = n_prev;
    m_cnt = n_cnt; m_word = n_word;
    for (int k = 0; k < N; k++) begin
      if (obs_rd[k] && srcq[k].size() != 0) out_reg[k] = srcq[k].pop_front();
    end
    drive_src();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int base, cnt_bad, pushes0;
    rst = 1'b1; enable = 1'b0; req_mask = '0; dst_full = 1'b0; dst_almost_full = 1'b0;
    for (int k = 0; k < N; k++) out_reg[k] = '0;
    for (int k = 0; k < N; k++) begin
      srcq[k].push_back(DW'(k)); srcq[k].push_back(DW'(k + 8));
    end
    drive_src();

    // Reset held two cycles with all sources non-empty
    @(posedge clk);
    #1;
    m_burst = 0; m_infl = 0; m_own = 0; m_prev = N - 1; m_cnt = 0; m_word = '0;
    @(negedge clk);
    enable = 1'b1; req_mask = 4'b1111;
    cycle();
    rst = 1'b0;
    cycle();
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_pop", 32'(src_rd_en), 32'h1);
    run(3);
    rst = 1'b1;
    cycle();
    clear_srcs();
    cycle();

    // Round-robin with 3 words per source
    for (int k = 0; k < N; k++)
      for (int i = 1; i <= 3; i++) load(k, DW'(k*4 + i));
    rst = 1'b0;
    pop_log.delete(); push_log.delete();
    run(40);
    chk("rr_pop_count", 32'(pop_log.size()), 32'd12);
    chk("rr_push_count", 32'(push_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < pop_log.size(); i++)  chk("rr_pop_order", 32'(pop_log[i]), 32'(rr_pops[i]));
    for (int i = 0; i < 12 && i < push_log.size(); i++) chk("rr_push_data", 32'(push_log[i]), 32'(rr_data[i]));

    // Short source: source 1 holds a single word
    pop_log.delete();
    for (int k = 0; k < N; k++) begin
      load(k, DW'($urandom));
      if (k != 1) load(k, DW'($urandom));
    end
    run(30);
    chk("short_pop_count", 32'(pop_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < pop_log.size(); i++) chk("short_pop_order", 32'(pop_log[i]), 32'(sh_pops[i]));

    // Backpressure: almost-full for 5 cycles right after the first pop
    pop_log.delete(); push_log.delete();
    for (int k = 0; k < N; k++) for (int i = 0; i < 3; i++) load(k, DW'($urandom));
    run(2);
    chk("bp_first_pop", 32'(pop_log.size()), 32'd1);
    dst_almost_full = 1'b1;
    base = pop_log.size();
    run(5);
    chk("bp_no_pop_stalled", 32'(pop_log.size() - base), 32'd0);
    dst_almost_full = 1'b0;
    cycle();
    chk("bp_resume_pop", 32'(pop_log.size() - base), 32'd1);
    run(40);
    chk("bp_push_total", 32'(push_log.size()), 32'd12);

    // Mask 0101: only sources 0 and 2, alternating
    pop_log.delete();
    req_mask = 4'b0101;
    for (int k = 0; k < N; k++) for (int i = 0; i < 4; i++) load(k, DW'($urandom));
    run(30);
    cnt_bad = 0;
    foreach (pop_log[i]) if (pop_log[i] != 0 && pop_log[i] != 2) cnt_bad++;
    chk("mask_only_0_2", 32'(cnt_bad), 32'd0);
    chk("mask_pop_count", 32'(pop_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("mask_pop_order", 32'(pop_log[i]), 32'(mk_pops[i]));
    clear_srcs();

    // Reset in the cycle after a pop
    req_mask = 4'b1111;
    for (int k = 0; k < N; k++) for (int i = 0; i < 3; i++) load(k, DW'($urandom));
    base = pop_log.size();
    for (int i = 0; i < 10 && pop_log.size() == base; i++) cycle();
    chk("rstb_pop_seen", 32'(pop_log.size() > base), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rstb_wr_en", 32'(dst_wr_en), 32'd0);
    chk("rstb_busy", 32'(busy), 32'd0);
    cycle();
    chk("rstb_regrant", 32'(grant), 32'h1);
    pushes0 = push_log.size();
    run(40);
    chk("rstb_drained", 32'(src_empty), 32'hf);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req_mask        = N'($urandom);
      enable          = ($urandom_range(0, 9) != 0);
      dst_almost_full = ($urandom_range(0, 3) == 0);
      dst_full        = dst_almost_full && ($urandom_range(0, 1) == 1);
      rst             = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) begin
        int k;
        k = int'($urandom_range(0, N - 1));
        if (srcq[k].size() < 8) load(k, DW'($urandom));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
